// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe encodings: game states, winner codes, line masks.
// Optional win-line output is enabled by defining TTT_WIN_LINE_EN.
package ttt_pkg;

  localparam logic [1:0] ST_PLAY  = 2'b00;
  localparam logic [1:0] ST_CHECK = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [8:0] LINE_R1 = 9'h007;
  localparam logic [8:0] LINE_R2 = 9'h038;
  localparam logic [8:0] LINE_R3 = 9'h1C0;
  localparam logic [8:0] LINE_C1 = 9'h049;
  localparam logic [8:0] LINE_C2 = 9'h092;
  localparam logic [8:0] LINE_C3 = 9'h124;
  localparam logic [8:0] LINE_DG = 9'h111;
  localparam logic [8:0] LINE_AD = 9'h054;

  localparam logic [8:0] BOARD_FULL = 9'h1FF;

  function automatic logic is_onehot9(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational check of all 8 lines of one 9-bit board.
// Bit order of o_hit matches the win_line mask layout.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [8:0] i_board,
  output logic [7:0] o_hit
);

  assign o_hit[0] = (i_board & LINE_R1) == LINE_R1;
  assign o_hit[1] = (i_board & LINE_R2) == LINE_R2;
  assign o_hit[2] = (i_board & LINE_R3) == LINE_R3;
  assign o_hit[3] = (i_board & LINE_C1) == LINE_C1;
  assign o_hit[4] = (i_board & LINE_C2) == LINE_C2;
  assign o_hit[5] = (i_board & LINE_C3) == LINE_C3;
  assign o_hit[6] = (i_board & LINE_DG) == LINE_DG;
  assign o_hit[7] = (i_board & LINE_AD) == LINE_AD;

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe board controller: move legality, one-cycle result check.
// Define TTT_WIN_LINE_EN to register and drive the winning-line mask.
module ttt_board_ctrl
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [8:0] cell_sel,
  output logic       move_accept,
  output logic       move_reject,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic [7:0] win_line
);

  logic [8:0] r_board_x;
  logic [8:0] r_board_o;
  logic       r_turn;
  logic [1:0] r_state;
  logic [1:0] r_winner;
  logic       r_accept;
  logic       r_reject;

  logic [8:0] w_occupied;
  logic       w_legal;
  logic [8:0] w_mover;
  logic [7:0] w_hits;
  logic       w_win;
  logic       w_full;

  assign w_occupied = r_board_x | r_board_o;
  assign w_legal    = is_onehot9(cell_sel)
                    && ((cell_sel & w_occupied) == 9'd0);
  assign w_mover    = r_turn ? r_board_o : r_board_x;
  assign w_win      = |w_hits;
  assign w_full     = w_occupied == BOARD_FULL;

  ttt_line_check u_line_check (
    .i_board (w_mover),
    .o_hit   (w_hits)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_board_x <= 9'd0;
      r_board_o <= 9'd0;
      r_turn    <= FIRST_PLAYER;
      r_state   <= ST_PLAY;
      r_winner  <= WIN_NONE;
      r_accept  <= 1'b0;
      r_reject  <= 1'b0;
    end else if (new_game) begin
      r_board_x <= 9'd0;
      r_board_o <= 9'd0;
      r_turn    <= FIRST_PLAYER;
      r_state   <= ST_PLAY;
      r_winner  <= WIN_NONE;
      r_accept  <= 1'b0;
      r_reject  <= 1'b0;
    end else begin
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        ST_PLAY: begin
          if (move_valid) begin
            if (w_legal) begin
              if (r_turn) r_board_o <= r_board_o | cell_sel;
              else        r_board_x <= r_board_x | cell_sel;
              r_accept <= 1'b1;
              r_state  <= ST_CHECK;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          r_reject <= move_valid;
          if (w_win) begin
            r_state  <= ST_DONE;
            r_winner <= r_turn ? WIN_O : WIN_X;
          end else if (w_full) begin
            r_state  <= ST_DONE;
            r_winner <= WIN_DRAW;
          end else begin
            r_turn  <= ~r_turn;
            r_state <= ST_PLAY;
          end
        end
        ST_DONE: begin
          r_reject <= move_valid;
        end
        default: begin
          r_state <= ST_PLAY;
        end
      endcase
    end
  end

`ifdef TTT_WIN_LINE_EN
  logic [7:0] r_win_line;

  always_ff @(posedge clk) begin
    if (!rst_n || new_game) begin
      r_win_line <= 8'd0;
    end else if (r_state == ST_CHECK && w_win) begin
      r_win_line <= w_hits;
    end
  end

  assign win_line = r_win_line;
`else
  assign win_line = 8'd0;
`endif

  assign move_accept = r_accept;
  assign move_reject = r_reject;
  assign board_x     = r_board_x;
  assign board_o     = r_board_o;
  assign turn        = r_turn;
  assign game_state  = r_state;
  assign winner      = r_winner;

endmodule
